// File: rtl/pipe_exec_core.sv
// rtl/pipe_exec_core.sv - 4-stage in-order execution core with forwarding and load-use interlock
module pipe_exec_core #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic [WIDTH-1:0]         in_imm,
  input  logic                     flush,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [WIDTH-1:0]         wb_data,
  output logic                     busy,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int RW = $clog2(NREGS);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LSL   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_LSR   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;

  // rs1 is a true source for ALU ops and LOAD
  function automatic logic reads_rs1(input logic [3:0] op);
    return op <= OP_LOAD;
  endfunction

  // rs2 is a true source for register-register ALU ops and STORE data
  function automatic logic reads_rs2(input logic [3:0] op);
    return ((op <= OP_XOR) && (op != OP_ADDI)) || (op == OP_STORE);
  endfunction

  // S1: issued instruction plus operands captured at acceptance
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [RW-1:0]    s1_rd_q, s1_rd_d;
  logic [RW-1:0]    s1_rs1_q, s1_rs1_d;
  logic [RW-1:0]    s1_rs2_q, s1_rs2_d;
  logic [WIDTH-1:0] s1_imm_q, s1_imm_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // S2: ALU result (or memory address) and store data
  logic             s2_valid_q, s2_valid_d;
  logic [3:0]       s2_op_q, s2_op_d;
  logic [RW-1:0]    s2_rd_q, s2_rd_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic [WIDTH-1:0] s2_sdata_q, s2_sdata_d;

  // S3: final writeback value
  logic             s3_valid_q, s3_valid_d;
  logic             s3_wen_q, s3_wen_d;
  logic [RW-1:0]    s3_rd_q, s3_rd_d;
  logic [WIDTH-1:0] s3_data_q, s3_data_d;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] mem_q  [DEPTH];

  logic             load_use;
  logic             accept;
  logic             s2_fwd;
  logic [WIDTH-1:0] fwd_a, fwd_b, alu;
  logic [SW-1:0]    shamt;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  // Issue handshake: stall one cycle when the presented instruction needs a LOAD still in S1
  always_comb begin
    load_use = s1_valid_q && (s1_op_q == OP_LOAD) && (s1_rd_q != '0) &&
               ((reads_rs1(in_op) && (in_rs1 == s1_rd_q)) ||
                (reads_rs2(in_op) && (in_rs2 == s1_rd_q)));
    in_ready = !(load_use && !flush);
    accept   = in_valid && in_ready && !flush;
  end

  // S1 next state: read the register file, bypassing the write that lands at the same edge
  always_comb begin
    s1_valid_d = accept;
    s1_op_d    = in_op;
    s1_rd_d    = in_rd;
    s1_rs1_d   = in_rs1;
    s1_rs2_d   = in_rs2;
    s1_imm_d   = in_imm;
    s1_a_d     = regs_q[in_rs1];
    s1_b_d     = regs_q[in_rs2];
    if (s3_wen_q && (s3_rd_q == in_rs1)) s1_a_d = s3_data_q;
    if (s3_wen_q && (s3_rd_q == in_rs2)) s1_b_d = s3_data_q;
  end

  // Execute: forward from S2 (non-load) first, then S3, then the captured value
  always_comb begin
    s2_fwd = s2_valid_q && (s2_op_q < OP_LOAD) && (s2_rd_q != '0);
    fwd_a  = s1_a_q;
    fwd_b  = s1_b_q;
    if (s3_wen_q && (s3_rd_q == s1_rs1_q)) fwd_a = s3_data_q;
    if (s3_wen_q && (s3_rd_q == s1_rs2_q)) fwd_b = s3_data_q;
    if (s2_fwd && (s2_rd_q == s1_rs1_q))   fwd_a = s2_res_q;
    if (s2_fwd && (s2_rd_q == s1_rs2_q))   fwd_b = s2_res_q;
    shamt = fwd_b[SW-1:0];
    case (s1_op_q)
      OP_ADD:                     alu = fwd_a + fwd_b;
      OP_ADDI, OP_LOAD, OP_STORE: alu = fwd_a + s1_imm_q;
      OP_LSL:                     alu = fwd_a << shamt;
      OP_SUB:                     alu = fwd_a - fwd_b;
      OP_LSR:                     alu = fwd_a >> shamt;
      OP_AND:                     alu = fwd_a & fwd_b;
      OP_OR:                      alu = fwd_a | fwd_b;
      OP_XOR:                     alu = fwd_a ^ fwd_b;
      default:                    alu = '0;
    endcase
    s2_valid_d = s1_valid_q && !flush;
    s2_op_d    = s1_op_q;
    s2_rd_d    = s1_rd_q;
    s2_res_d   = alu;
    s2_sdata_d = fwd_b;
  end

  // Memory stage: word address from the low bits of the sum, load data read combinationally
  always_comb begin
    mem_addr   = s2_res_q[AW-1:0];
    mem_we     = s2_valid_q && (s2_op_q == OP_STORE);
    mem_rdata  = mem_q[mem_addr];
    s3_valid_d = s2_valid_q;
    s3_wen_d   = s2_valid_q && (s2_op_q <= OP_LOAD) && (s2_rd_q != '0);
    s3_rd_d    = s2_rd_q;
    s3_data_d  = (s2_op_q == OP_LOAD) ? mem_rdata : s2_res_q;
  end

  // Register file update from S3; r0 is never written so it always reads zero
  always_comb begin
    regs_d = regs_q;
    if (s3_wen_q) regs_d[s3_rd_q] = s3_data_q;
  end

  // Pipeline and register file state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_op_q    <= '0;
      s2_rd_q    <= '0;
      s2_res_q   <= '0;
      s2_sdata_q <= '0;
      s3_valid_q <= 1'b0;
      s3_wen_q   <= 1'b0;
      s3_rd_q    <= '0;
      s3_data_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_rd_q    <= s1_rd_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_imm_q   <= s1_imm_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      s2_rd_q    <= s2_rd_d;
      s2_res_q   <= s2_res_d;
      s2_sdata_q <= s2_sdata_d;
      s3_valid_q <= s3_valid_d;
      s3_wen_q   <= s3_wen_d;
      s3_rd_q    <= s3_rd_d;
      s3_data_q  <= s3_data_d;
      regs_q     <= regs_d;
    end
  end

  // Data memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= s2_sdata_q;
  end

  assign wb_valid = s3_wen_q;
  assign wb_rd    = s3_rd_q;
  assign wb_data  = s3_data_q;
  assign busy     = s1_valid_q || s2_valid_q || s3_valid_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_pipe_exec_core.sv
// tb/tb_pipe_exec_core.sv - self-checking bench for pipe_exec_core
module tb_pipe_exec_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  pipe_exec_core #(.WIDTH(32), .NREGS(32), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm, exp;
    bit          exp_wb;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } instr_t;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } wbexp_t;

  vec_t        vt [11];
  wbexp_t      sbq [$];
  instr_t      m_s1;
  bit          m_s1_v = 0;
  int          edge_n = 0;
  logic [31:0] m_rf [32];
  logic [31:0] m_mem [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input bit fl);
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; flush = fl;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    drive(1, op, rd, rs1, rs2, imm, 0);
    #1;
    chk("issue_ready", in_ready, 1);
    tick();
  endtask

  task automatic idle();
    drive(0, 4'd15, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
    dbg_addr = r;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic do_reset();
    drive(0, 4'd15, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bit ref_rs1(input logic [3:0] op);
    return op <= 4'd8;
  endfunction

  function automatic bit ref_rs2(input logic [3:0] op);
    return ((op <= 4'd7) && (op != 4'd1)) || (op == 4'd9);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    case (op)
      4'd0:             return a + b;
      4'd1, 4'd8, 4'd9: return a + imm;
      4'd2:             return a << (b % 32);
      4'd3:             return a - b;
      4'd4:             return a >> (b % 32);
      4'd5:             return a & b;
      4'd6:             return a | b;
      4'd7:             return a ^ b;
      default:          return 32'd0;
    endcase
  endfunction

  // One cycle against the sequential architectural model; starts and ends at a negedge
  task automatic step(input bit v, input instr_t ins, input bit fl);
    bit          exp_rdy;
    logic [31:0] a, b, res;
    wbexp_t      e;
    if (sbq.size() > 0 && sbq[0].due == edge_n) begin
      e = sbq.pop_front();
      chk("rnd_wb_valid", wb_valid, 1);
      chk("rnd_wb_rd", wb_rd, e.rd);
      chk("rnd_wb_data", wb_data, e.data);
    end else begin
      chk("rnd_wb_valid", wb_valid, 0);
    end
    drive(v, ins.op, ins.rd, ins.rs1, ins.rs2, ins.imm, fl);
    #1;
    exp_rdy = !(m_s1_v && m_s1.op == 4'd8 && m_s1.rd != 0 &&
                ((ref_rs1(ins.op) && ins.rs1 == m_s1.rd) || (ref_rs2(ins.op) && ins.rs2 == m_s1.rd)));
    if (!fl) chk("rnd_in_ready", in_ready, exp_rdy);
    @(posedge clk);
    edge_n++;
    if (m_s1_v && !fl) begin
      a   = m_rf[m_s1.rs1];
      b   = m_rf[m_s1.rs2];
      res = ref_alu(m_s1.op, a, b, m_s1.imm);
      if (m_s1.op == 4'd9) m_mem[res % 64] = b;
      else if (m_s1.op == 4'd8) res = m_mem[res % 64];
      if (m_s1.op <= 4'd8 && m_s1.rd != 0) begin
        m_rf[m_s1.rd] = res;
        sbq.push_back('{due: edge_n + 1, rd: m_s1.rd, data: res});
      end
    end
    m_s1_v = v && exp_rdy && !fl;
    m_s1   = ins;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instr_t ins;
    bit     v, fl;

    vt[0]  = '{op: 4'd0,  a: 32'd5,          b: 32'd7,          imm: 32'd0,          exp: 32'd12,         exp_wb: 1};
    vt[1]  = '{op: 4'd1,  a: 32'd5,          b: 32'd0,          imm: 32'hFFFF_FFFF,  exp: 32'd4,          exp_wb: 1};
    vt[2]  = '{op: 4'd2,  a: 32'd1,          b: 32'd33,         imm: 32'd0,          exp: 32'd2,          exp_wb: 1};
    vt[3]  = '{op: 4'd3,  a: 32'd3,          b: 32'd5,          imm: 32'd0,          exp: 32'hFFFF_FFFE,  exp_wb: 1};
    vt[4]  = '{op: 4'd4,  a: 32'h8000_0000,  b: 32'd31,         imm: 32'd0,          exp: 32'd1,          exp_wb: 1};
    vt[5]  = '{op: 4'd5,  a: 32'hF0F0_1234,  b: 32'h0FF0_FFFF,  imm: 32'd0,          exp: 32'h00F0_1234,  exp_wb: 1};
    vt[6]  = '{op: 4'd6,  a: 32'hF000_0000,  b: 32'h0000_000F,  imm: 32'd0,          exp: 32'hF000_000F,  exp_wb: 1};
    vt[7]  = '{op: 4'd7,  a: 32'hFFFF_0000,  b: 32'h0F0F_0F0F,  imm: 32'd0,          exp: 32'hF0F0_0F0F,  exp_wb: 1};
    vt[8]  = '{op: 4'd0,  a: 32'hFFFF_FFFF,  b: 32'd1,          imm: 32'd0,          exp: 32'd0,          exp_wb: 1};
    vt[9]  = '{op: 4'd4,  a: 32'h0000_0100,  b: 32'd36,         imm: 32'd0,          exp: 32'h10,         exp_wb: 1};
    vt[10] = '{op: 4'd12, a: 32'd9,          b: 32'd9,          imm: 32'd0,          exp: 32'd0,          exp_wb: 0};

    // Reset state
    do_reset();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // Two independent ADDIs: writebacks two edges after acceptance
    issue(4'd1, 5'd1, 5'd0, 5'd0, 32'd5);
    issue(4'd1, 5'd2, 5'd0, 5'd0, 32'd7);
    chk("s1_early_wb", wb_valid, 0);
    chk("s1_busy", busy, 1);
    idle();
    chk("s1_wb1_valid", wb_valid, 1);
    chk("s1_wb1_rd", wb_rd, 1);
    chk("s1_wb1_data", wb_data, 5);
    idle();
    chk("s1_wb2_valid", wb_valid, 1);
    chk("s1_wb2_rd", wb_rd, 2);
    chk("s1_wb2_data", wb_data, 7);
    chk_reg("s1_dbg_r1", 1, 5);
    idle();
    chk_reg("s1_dbg_r2", 2, 7);

    // Dependent chain through S2/S3 forwarding
    issue(4'd1, 5'd1, 5'd0, 5'd0, 32'd3);
    issue(4'd0, 5'd2, 5'd1, 5'd1, 32'd0);
    issue(4'd3, 5'd3, 5'd2, 5'd1, 32'd0);
    chk("dep_wb_r1", wb_data, 3);
    idle();
    chk("dep_wb_r2", wb_data, 6);
    idle();
    chk("dep_wb_r3", wb_data, 3);
    idle();
    chk_reg("dep_dbg_r2", 2, 6);
    chk_reg("dep_dbg_r3", 3, 3);

    // Load-use interlock
    issue(4'd1, 5'd1, 5'd0, 5'd0, 32'd9);
    issue(4'd9, 5'd0, 5'd0, 5'd1, 32'd4);
    issue(4'd8, 5'd5, 5'd0, 5'd0, 32'd4);
    drive(1, 4'd0, 5'd6, 5'd5, 5'd5, 32'd0, 0);
    #1;
    chk("lu_stall_ready", in_ready, 0);
    tick();
    #1;
    chk("lu_retry_ready", in_ready, 1);
    tick();
    chk("lu_load_wb_rd", wb_rd, 5);
    chk("lu_load_wb_data", wb_data, 9);
    idle();
    chk("lu_bubble_wb", wb_valid, 0);
    idle();
    chk("lu_add_wb_valid", wb_valid, 1);
    chk("lu_add_wb_rd", wb_rd, 6);
    chk("lu_add_wb_data", wb_data, 18);
    idle();
    chk("lu_single_wb", wb_valid, 0);

    // Table of ALU vectors: operands loaded then used back-to-back
    for (int i = 0; i < 11; i++) begin
      issue(4'd1, 5'd1, 5'd0, 5'd0, vt[i].a);
      issue(4'd1, 5'd2, 5'd0, 5'd0, vt[i].b);
      issue(vt[i].op, 5'd3, 5'd1, 5'd2, vt[i].imm);
      idle();
      idle();
      chk($sformatf("vec%0d_wb_valid", i), wb_valid, vt[i].exp_wb);
      if (vt[i].exp_wb) begin
        chk($sformatf("vec%0d_wb_rd", i), wb_rd, 3);
        chk($sformatf("vec%0d_wb_data", i), wb_data, vt[i].exp);
        idle();
        chk_reg($sformatf("vec%0d_dbg_r3", i), 3, vt[i].exp);
      end
    end

    // Wrap-around arithmetic and memory address wrap
    issue(4'd1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    issue(4'd1, 5'd2, 5'd1, 5'd0, 32'd1);
    issue(4'd1, 5'd3, 5'd0, 5'd0, 32'd1);
    issue(4'd1, 5'd4, 5'd0, 5'd0, 32'd33);
    issue(4'd2, 5'd5, 5'd3, 5'd4, 32'd0);
    issue(4'd9, 5'd0, 5'd0, 5'd1, 32'd65);
    issue(4'd8, 5'd6, 5'd0, 5'd0, 32'd1);
    repeat (4) idle();
    chk_reg("wrap_r1", 1, 32'hFFFF_FFFF);
    chk_reg("wrap_r2", 2, 32'd0);
    chk_reg("wrap_lsl33", 5, 32'd2);
    chk_reg("wrap_mem65", 6, 32'hFFFF_FFFF);

    // r0 is never written
    issue(4'd1, 5'd0, 5'd0, 5'd0, 32'd9);
    idle();
    idle();
    chk("r0_wb_valid", wb_valid, 0);
    idle();
    chk_reg("r0_dbg", 0, 0);

    // Flush kills S1 and the presented instruction, older work retires
    issue(4'd1, 5'd10, 5'd0, 5'd0, 32'd1);
    issue(4'd1, 5'd11, 5'd0, 5'd0, 32'd2);
    drive(1, 4'd1, 5'd12, 5'd0, 5'd0, 32'd3, 1);
    tick();
    chk("fl_old_wb_valid", wb_valid, 1);
    chk("fl_old_wb_rd", wb_rd, 10);
    idle();
    chk("fl_killed_wb", wb_valid, 0);
    idle();
    chk("fl_input_wb", wb_valid, 0);
    chk("fl_busy", busy, 0);
    chk_reg("fl_r10", 10, 1);
    chk_reg("fl_r11", 11, 0);
    chk_reg("fl_r12", 12, 0);

    // Mid-operation reset with all stages full; memory survives
    issue(4'd1, 5'd1, 5'd0, 5'd0, 32'h55);
    issue(4'd9, 5'd0, 5'd0, 5'd1, 32'd10);
    issue(4'd1, 5'd2, 5'd0, 5'd0, 32'd1);
    issue(4'd1, 5'd3, 5'd0, 5'd0, 32'd2);
    issue(4'd1, 5'd4, 5'd0, 5'd0, 32'd3);
    drive(0, 4'd15, 0, 0, 0, 0, 0);
    chk("mr_busy_before", busy, 1);
    chk("mr_wb_before", wb_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_wb_valid", wb_valid, 0);
    chk("mr_wb_rd", wb_rd, 0);
    chk("mr_wb_data", wb_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_in_ready", in_ready, 1);
    chk_reg("mr_r1", 1, 0);
    @(negedge clk);
    reset = 1'b0;
    issue(4'd8, 5'd5, 5'd0, 5'd0, 32'd10);
    idle();
    idle();
    chk("mr_load_wb", wb_data, 32'h55);
    idle();
    chk_reg("mr_load_r5", 5, 32'h55);

    // Randomized run against the architectural model
    do_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_s1_v = 0;
    sbq.delete();
    for (int i = 0; i < 64; i++) begin
      ins = '{op: 4'd9, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'(i)};
      step(1, ins, 0);
    end
    for (int n = 0; n < 1500; n++) begin
      ins.op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ins.rd  = 5'($urandom_range(0, 7));
      ins.rs1 = 5'($urandom_range(0, 7));
      ins.rs2 = 5'($urandom_range(0, 7));
      ins.imm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 70));
      v  = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 19) == 0);
      // a STORE base register is not interlocked against a LOAD in S1, so keep it independent
      if (ins.op == 4'd9 && m_s1_v && m_s1.op == 4'd8 && m_s1.rd != 0 && ins.rs1 == m_s1.rd) ins.rs1 = 5'd0;
      step(v, ins, fl);
    end
    ins = '{op: 4'd15, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0};
    repeat (4) step(0, ins, 0);
    chk("rnd_queue_drained", sbq.size(), 0);
    for (int i = 0; i < 32; i++) chk_reg($sformatf("rnd_reg%0d", i), 5'(i), m_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
